// File: rtl/mips_pkg.sv
// Shared MIPS32 multi-cycle definitions: opcodes, FSM states
// and the datapath mux/ALU select codes driven by the control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEX    = 4'd11,
        S_IWB    = 4'd12,
        S_JAL    = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BR   = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Instruction-class dispatch out of DECODE; unknown opcodes trap.
    function automatic state_t decode_next(
        input logic [5:0] op,
        input logic       jal_en
    );
        state_t nxt;
        case (op)
            OP_RTYPE:        nxt = S_REX;
            OP_LW, OP_SW:    nxt = S_MEMADR;
            OP_BEQ, OP_BNE:  nxt = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI:
                             nxt = S_IEX;
            OP_J:            nxt = S_JUMP;
            OP_JAL:          nxt = jal_en ? S_JAL : S_TRAP;
            default:         nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state and flags a timeout
// when the stall reaches MEM_TIMEOUT (0 disables the flag).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] MAX   = '1;

    logic [CNT_W-1:0] count;
    logic             stalled;

    assign stalled = waiting && !mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && stalled && (count == LIMIT);

    // Count stalled cycles; any ready, exit or trap restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!stalled || timeout) begin
            count <= '0;
        end else if (count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 control FSM: fetch/decode/execute/mem/writeback
// sequencing with a bounded memory wait and a sticky trap state.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4,
    parameter int ENABLE_JAL  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_beq,
    output logic       o_pc_write_bne,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_memto_reg,
    output logic [1:0] o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic [3:0] o_state,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    state_t     state;
    state_t     dec_next;
    logic [1:0] fault_code;
    logic       mem_wait;
    logic       timeout;

    assign mem_wait = (state == S_FETCH) ||
                      (state == S_MEMRD) ||
                      (state == S_MEMWR);

    assign dec_next     = decode_next(i_opcode, ENABLE_JAL != 0);
    assign o_state      = state;
    assign o_fault_code = fault_code;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .waiting   (mem_wait),
        .mem_ready (i_mem_ready),
        .timeout   (timeout)
    );

    // State sequencing and sticky fault cause capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_RESET;
            fault_code <= FAULT_NONE;
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: begin
                    if (i_mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout) begin
                        state      <= S_TRAP;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    state <= dec_next;
                    if (dec_next == S_TRAP) begin
                        fault_code <= FAULT_ILLEGAL;
                    end
                end
                S_MEMADR: begin
                    state <= (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (i_mem_ready) begin
                        state <= S_MEMWB;
                    end else if (timeout) begin
                        state      <= S_TRAP;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end
                S_MEMWR: begin
                    if (i_mem_ready) begin
                        state <= S_FETCH;
                    end else if (timeout) begin
                        state      <= S_TRAP;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end
                S_REX:    state <= S_ALUWB;
                S_IEX:    state <= S_IWB;
                S_MEMWB,
                S_ALUWB,
                S_IWB,
                S_BRANCH,
                S_JUMP,
                S_JAL:    state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_TRAP;
            endcase
        end
    end

    // Per-state control decode; FETCH loads IR/PC only on mem ready.
    always_comb begin
        o_pc_write     = 1'b0;
        o_pc_write_beq = 1'b0;
        o_pc_write_bne = 1'b0;
        o_iord         = 1'b0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_ir_write     = 1'b0;
        o_memto_reg    = 1'b0;
        o_reg_dst      = REGDST_RT;
        o_reg_write    = 1'b0;
        o_alu_src_a    = 1'b0;
        o_alu_src_b    = ALUB_RT;
        o_alu_op       = ALUOP_ADD;
        o_pc_source    = PCSRC_ALU;
        o_fault        = 1'b0;
        case (state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = ALUB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = ALUB_BR;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write = 1'b1;
                o_memto_reg = 1'b1;
            end
            S_MEMWR: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_REX: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = REGDST_RD;
            end
            S_IEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_IMM;
                o_alu_op    = ALUOP_IMM;
            end
            S_IWB: begin
                o_reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a    = 1'b1;
                o_alu_op       = ALUOP_SUB;
                o_pc_source    = PCSRC_ALUOUT;
                o_pc_write_beq = (i_opcode == OP_BEQ);
                o_pc_write_bne = (i_opcode == OP_BNE);
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
                o_reg_write = 1'b1;
                o_reg_dst   = REGDST_RA;
            end
            S_TRAP: begin
                o_fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
